// File: rtl/sdes_iter_core.sv
// Iterative Simplified-DES core: one Feistel round per clock, NUM_ROUNDS rounds per block,
// with a valid/ready request port and a result held until the consumer takes it.
`timescale 1ns/1ps

module sdes_iter_core #(
   parameter int NUM_ROUNDS = 2
) (
   input  logic       CLOCK_50,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic [9:0] in_key,
   input  logic       in_decrypt,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       busy
);

   localparam int CW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
   localparam logic [CW-1:0] LAST_ROUND = CW'(NUM_ROUNDS - 1);
   // Decryption starts from the last round key, i.e. the halves rotated by 2N-1.
   localparam int DEC_ROT = (2 * NUM_ROUNDS - 1) % 5;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      DONE
   } StateT;

   StateT r_state;
   StateT w_nextState;

   logic [7:0]    r_block;
   logic          r_decrypt;
   logic [CW-1:0] r_count;
   logic [9:0]    r_keyState;
   logic [7:0]    r_outData;

   logic [9:0] w_p10;
   logic [9:0] w_keyEnc;
   logic [9:0] w_keyDec;
   logic [7:0] w_roundKey;
   logic [3:0] w_fOut;
   logic [3:0] w_mixedL;
   logic       w_lastRound;
   logic       w_accept;

   function automatic logic [9:0] fP10(input logic [9:0] k);
      return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
   endfunction

   function automatic logic [7:0] fP8(input logic [9:0] k);
      return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
   endfunction

   function automatic logic [7:0] fIP(input logic [7:0] d);
      return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
   endfunction

   function automatic logic [7:0] fIPInv(input logic [7:0] d);
      return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
   endfunction

   function automatic logic [7:0] fEP(input logic [3:0] r);
      return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
   endfunction

   function automatic logic [3:0] fP4(input logic [3:0] s);
      return {s[2], s[0], s[1], s[3]};
   endfunction

   function automatic logic [4:0] rotl5(input logic [4:0] x, input int amt);
      case (amt)
         1:       return {x[3:0], x[4]};
         2:       return {x[2:0], x[4:3]};
         3:       return {x[1:0], x[4:2]};
         4:       return {x[0], x[4:1]};
         default: return x;
      endcase
   endfunction

   // S-box address is {row, col}: row from outer bits 1,4, column from inner bits 2,3.
   function automatic logic [1:0] sbox0(input logic [3:0] x);
      case ({x[3], x[0], x[2], x[1]})
         4'd0:  return 2'd1;  4'd1:  return 2'd0;
         4'd2:  return 2'd3;  4'd3:  return 2'd2;
         4'd4:  return 2'd3;  4'd5:  return 2'd2;
         4'd6:  return 2'd1;  4'd7:  return 2'd0;
         4'd8:  return 2'd0;  4'd9:  return 2'd2;
         4'd10: return 2'd1;  4'd11: return 2'd3;
         4'd12: return 2'd3;  4'd13: return 2'd1;
         4'd14: return 2'd3;  default: return 2'd2;
      endcase
   endfunction

   function automatic logic [1:0] sbox1(input logic [3:0] x);
      case ({x[3], x[0], x[2], x[1]})
         4'd0:  return 2'd0;  4'd1:  return 2'd1;
         4'd2:  return 2'd2;  4'd3:  return 2'd3;
         4'd4:  return 2'd2;  4'd5:  return 2'd0;
         4'd6:  return 2'd1;  4'd7:  return 2'd3;
         4'd8:  return 2'd3;  4'd9:  return 2'd0;
         4'd10: return 2'd1;  4'd11: return 2'd0;
         4'd12: return 2'd2;  4'd13: return 2'd1;
         4'd14: return 2'd0;  default: return 2'd3;
      endcase
   endfunction

   function automatic logic [3:0] fF(input logic [3:0] r, input logic [7:0] sk);
      logic [7:0] e;
      e = fEP(r) ^ sk;
      return fP4({sbox0(e[7:4]), sbox1(e[3:0])});
   endfunction

   assign w_p10       = fP10(in_key);
   assign w_keyEnc    = {rotl5(w_p10[9:5], 1), rotl5(w_p10[4:0], 1)};
   assign w_keyDec    = {rotl5(w_p10[9:5], DEC_ROT), rotl5(w_p10[4:0], DEC_ROT)};
   assign w_roundKey  = fP8(r_keyState);
   assign w_fOut      = fF(r_block[3:0], w_roundKey);
   assign w_mixedL    = r_block[7:4] ^ w_fOut;
   assign w_lastRound = (r_count == LAST_ROUND);
   assign w_accept    = in_valid & in_ready;
   assign out_data    = r_outData;

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               w_nextState = ROUND;
            end
         end
         ROUND: begin
            if (w_lastRound) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            busy        = 1'b0;
            w_nextState = IDLE;
         end
      endcase
   end

   // The final round skips the swap and writes the result straight through IP^-1.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         r_block    <= 8'h00;
         r_decrypt  <= 1'b0;
         r_count    <= '0;
         r_keyState <= 10'h000;
         r_outData  <= 8'h00;
      end else if (w_accept) begin
         r_block    <= fIP(in_data);
         r_decrypt  <= in_decrypt;
         r_count    <= '0;
         r_keyState <= in_decrypt ? w_keyDec : w_keyEnc;
      end else if (r_state == ROUND) begin
         if (w_lastRound) begin
            r_outData <= fIPInv({w_mixedL, r_block[3:0]});
         end else begin
            r_block <= {r_block[3:0], w_mixedL};
            r_count <= r_count + CW'(1);
            if (r_decrypt) begin
               r_keyState <= {rotl5(r_keyState[9:5], 3), rotl5(r_keyState[4:0], 3)};
            end else begin
               r_keyState <= {rotl5(r_keyState[9:5], 2), rotl5(r_keyState[4:0], 2)};
            end
         end
      end
   end

endmodule

// File: tb/tb_sdes_iter_core.sv
// Bench for sdes_iter_core: several instances with different round counts, a table-driven
// S-DES reference model, and a per-cycle protocol/result comparison against it.
`timescale 1ns/1ps

module tb_sdes_iter_core;

   localparam int ND = 5;
   localparam int NRS [ND] = '{2, 4, 1, 16, 3};

   localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
   localparam int P8_T  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
   localparam int IP_T  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
   localparam int IPI_T [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
   localparam int EP_T  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
   localparam int P4_T  [4]  = '{2, 4, 3, 1};
   localparam int S0_T  [16] = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
   localparam int S1_T  [16] = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       inValid   [ND];
   logic       inReady   [ND];
   logic [7:0] inData    [ND];
   logic [9:0] inKey     [ND];
   logic       inDecrypt [ND];
   logic       outValid  [ND];
   logic       outReady  [ND];
   logic [7:0] outData   [ND];
   logic       busy      [ND];

   int checks   = 0;
   int failures = 0;

   int         mState [ND];
   int         mCnt   [ND];
   logic [7:0] mOut   [ND];
   logic [7:0] mPend  [ND];

   always #5 clock = ~clock;

   for (genvar g = 0; g < ND; g++) begin : gDut
      sdes_iter_core #(.NUM_ROUNDS(NRS[g])) dut (
         .CLOCK_50  (clock),
         .rst       (reset),
         .in_valid  (inValid[g]),
         .in_ready  (inReady[g]),
         .in_data   (inData[g]),
         .in_key    (inKey[g]),
         .in_decrypt(inDecrypt[g]),
         .out_valid (outValid[g]),
         .out_ready (outReady[g]),
         .out_data  (outData[g]),
         .busy      (busy[g])
      );
   end

   // Reference model: tables indexed by S-DES bit position (bit 1 = MSB).
   function automatic logic [9:0] mP10(input logic [9:0] k);
      logic [9:0] r;
      for (int j = 0; j < 10; j++) r[9-j] = k[10-P10_T[j]];
      return r;
   endfunction

   function automatic logic [7:0] mP8(input logic [9:0] k);
      logic [7:0] r;
      for (int j = 0; j < 8; j++) r[7-j] = k[10-P8_T[j]];
      return r;
   endfunction

   function automatic logic [7:0] mIP(input logic [7:0] d);
      logic [7:0] r;
      for (int j = 0; j < 8; j++) r[7-j] = d[8-IP_T[j]];
      return r;
   endfunction

   function automatic logic [7:0] mIPI(input logic [7:0] d);
      logic [7:0] r;
      for (int j = 0; j < 8; j++) r[7-j] = d[8-IPI_T[j]];
      return r;
   endfunction

   function automatic logic [3:0] mF(input logic [3:0] rr, input logic [7:0] sk);
      logic [7:0] e;
      logic [3:0] s;
      logic [3:0] p;
      int s0;
      int s1;
      for (int j = 0; j < 8; j++) e[7-j] = rr[4-EP_T[j]];
      e  = e ^ sk;
      s0 = S0_T[{e[7], e[4], e[6], e[5]}];
      s1 = S1_T[{e[3], e[0], e[2], e[1]}];
      s  = {s0[1:0], s1[1:0]};
      for (int j = 0; j < 4; j++) p[3-j] = s[4-P4_T[j]];
      return p;
   endfunction

   function automatic logic [4:0] mRot5(input logic [4:0] x, input int a);
      logic [9:0] t;
      t = {x, x} << a;
      return t[9:5];
   endfunction

   function automatic logic [7:0] mSubkey(input logic [9:0] k, input int r);
      logic [9:0] p;
      int a;
      p = mP10(k);
      a = (2 * r - 1) % 5;
      return mP8({mRot5(p[9:5], a), mRot5(p[4:0], a)});
   endfunction

   function automatic logic [7:0] mCipher(input logic [7:0] d, input logic [9:0] k,
                                          input logic dec, input int n);
      logic [7:0] b;
      logic [3:0] l;
      logic [3:0] r;
      logic [3:0] t;
      int idx;
      b = mIP(d);
      l = b[7:4];
      r = b[3:0];
      for (int i = 0; i < n; i++) begin
         idx = dec ? (n - i) : (i + 1);
         t   = l ^ mF(r, mSubkey(k, idx));
         if (i == n - 1) begin
            l = t;
         end else begin
            l = r;
            r = t;
         end
      end
      return mIPI({l, r});
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Protocol model: 0 idle, 1 computing (mCnt edges left), 2 holding a result.
   always @(posedge clock) begin
      for (int d = 0; d < ND; d++) begin
         if (reset) begin
            mState[d] <= 0;
            mCnt[d]   <= 0;
            mOut[d]   <= 8'h00;
         end else begin
            case (mState[d])
               0: if (inValid[d]) begin
                  mState[d] <= 1;
                  mCnt[d]   <= NRS[d];
                  mPend[d]  <= mCipher(inData[d], inKey[d], inDecrypt[d], NRS[d]);
               end
               1: begin
                  if (mCnt[d] == 1) begin
                     mState[d] <= 2;
                     mOut[d]   <= mPend[d];
                  end
                  mCnt[d] <= mCnt[d] - 1;
               end
               default: if (outReady[d]) mState[d] <= 0;
            endcase
         end
      end
   end

   always @(negedge clock) begin
      for (int d = 0; d < ND; d++) begin
         if (reset) begin
            checkOutput($sformatf("rstInReady[%0d]", d), inReady[d], 1);
            checkOutput($sformatf("rstOutValid[%0d]", d), outValid[d], 0);
            checkOutput($sformatf("rstBusy[%0d]", d), busy[d], 0);
            checkOutput($sformatf("rstOutData[%0d]", d), outData[d], 8'h00);
         end else begin
            checkOutput($sformatf("inReady[%0d]", d), inReady[d], mState[d] == 0);
            checkOutput($sformatf("outValid[%0d]", d), outValid[d], mState[d] == 2);
            checkOutput($sformatf("busy[%0d]", d), busy[d], mState[d] != 0);
            checkOutput($sformatf("outData[%0d]", d), outData[d], mOut[d]);
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic applyStimulus(input int d, input logic [7:0] data, input logic [9:0] key,
                                input logic dec);
      logic rdy;
      bit   taken;
      taken        = 0;
      inValid[d]   = 1'b1;
      inData[d]    = data;
      inKey[d]     = key;
      inDecrypt[d] = dec;
      for (int k = 0; k < 20 && !taken; k++) begin
         @(negedge clock);
         rdy = inReady[d];
         @(posedge clock);
         #1;
         taken = rdy;
      end
      if (!taken) checkOutput($sformatf("acceptTimeout[%0d]", d), 0, 1);
      inValid[d]   = 1'b0;
      inData[d]    = 8'($urandom);
      inKey[d]     = 10'($urandom);
      inDecrypt[d] = 1'($urandom);
   endtask

   task automatic collect(input int d, output logic [7:0] res, output int lat);
      bit got;
      got = 0;
      res = 'x;
      lat = -1;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(posedge clock);
         #1;
         if (outValid[d]) begin
            got = 1;
            lat = k;
            res = outData[d];
         end
      end
      if (!got) checkOutput($sformatf("resultTimeout[%0d]", d), 0, 1);
      else if (outReady[d]) waitCycles(1);
   endtask

   task automatic runTxn(input int d, input logic [7:0] data, input logic [9:0] key,
                         input logic dec, output logic [7:0] res);
      int lat;
      applyStimulus(d, data, key, dec);
      collect(d, res, lat);
      checkOutput($sformatf("latency[%0d]", d), lat, NRS[d]);
   endtask

   initial begin
      logic [7:0] res;
      logic [7:0] ct;
      logic [7:0] data;
      logic [9:0] key;
      for (int d = 0; d < ND; d++) begin
         inValid[d]   = 1'b0;
         inData[d]    = 8'h00;
         inKey[d]     = 10'h000;
         inDecrypt[d] = 1'b0;
         outReady[d]  = 1'b1;
         mState[d]    = 0;
         mCnt[d]      = 0;
         mOut[d]      = 8'h00;
         mPend[d]     = 8'h00;
      end
      reset = 1'b1;
      waitCycles(3);
      reset = 1'b0;
      waitCycles(1);

      checkOutput("modelK1", mSubkey(10'b1010000010, 1), 8'b10100100);
      checkOutput("modelK2", mSubkey(10'b1010000010, 2), 8'b01000011);
      checkOutput("modelEnc", mCipher(8'b10010111, 10'b1010000010, 1'b0, 2), 8'b00111000);
      checkOutput("modelDec", mCipher(8'b00111000, 10'b1010000010, 1'b1, 2), 8'b10010111);

      runTxn(0, 8'b10010111, 10'b1010000010, 1'b0, res);
      checkOutput("knownEnc", res, 8'b00111000);
      runTxn(0, 8'b00111000, 10'b1010000010, 1'b1, res);
      checkOutput("knownDec", res, 8'b10010111);

      for (int d = 0; d < ND; d++) begin
         for (int t = 0; t < 12; t++) begin
            data = 8'($urandom);
            key  = 10'($urandom);
            runTxn(d, data, key, 1'b0, ct);
            runTxn(d, ct, key, 1'b1, res);
            checkOutput($sformatf("roundTrip[%0d]", d), res, data);
         end
      end

      // Result must stay put under backpressure while inputs churn.
      outReady[0] = 1'b0;
      begin
         int lat;
         applyStimulus(0, 8'hA5, 10'h2C3, 1'b0);
         collect(0, res, lat);
         checkOutput("bpLatency", lat, 2);
      end
      for (int t = 0; t < 10; t++) begin
         inValid[0]   = 1'b1;
         inData[0]    = 8'($urandom);
         inKey[0]     = 10'($urandom);
         inDecrypt[0] = 1'(t);
         waitCycles(1);
         checkOutput("bpHoldData", outData[0], res);
         checkOutput("bpHoldValid", outValid[0], 1);
         checkOutput("bpNoReady", inReady[0], 0);
      end
      outReady[0] = 1'b1;
      waitCycles(1);
      inValid[0] = 1'b0;
      checkOutput("bpReleaseIdle", inReady[0], 1);
      checkOutput("bpReleaseValid", outValid[0], 0);
      waitCycles(2);
      checkOutput("bpNoAccept", busy[0], 0);

      applyStimulus(1, 8'h3C, 10'h1F0, 1'b0);
      waitCycles(2);
      reset = 1'b1;
      #1;
      checkOutput("midRstValid", outValid[1], 0);
      checkOutput("midRstData", outData[1], 8'h00);
      checkOutput("midRstReady", inReady[1], 1);
      waitCycles(2);
      reset = 1'b0;
      waitCycles(1);
      runTxn(1, 8'h3C, 10'h1F0, 1'b0, res);
      checkOutput("afterRst", res, mCipher(8'h3C, 10'h1F0, 1'b0, 4));

      for (int k = 0; k < 1024; k++) begin
         key = 10'(k);
         runTxn(0, key[7:0] ^ 8'h5A, key, key[0], res);
      end
      for (int d = 0; d < ND; d++) begin
         for (int b = 0; b < 256; b++) begin
            data = 8'(b);
            runTxn(d, data, 10'b1010000010, data[3], res);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3_000_000;
      failures++;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
